// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle.
// Define DIV_SIGNED_EN to honour op_signed (two's complement operands, overflow fast path).
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_signed,
    input  logic             op_rem,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIN  = 2'd2
    } state_t;

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t           state;
    state_t           state_next;
    logic [CW-1:0]    step_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dsr_q;
    logic             rem_sel_q;

    logic             launch;
    logic             div_zero;
    logic             overflow;
    logic             fast_path;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] fast_result;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] fix_quo;
    logic [WIDTH-1:0] fix_rem;

    assign launch   = (state == IDLE) && start;
    assign div_zero = (divisor == '0);

`ifdef DIV_SIGNED_EN
    logic sign_a;
    logic sign_b;
    logic neg_quo_q;
    logic neg_rem_q;

    assign sign_a   = op_signed & dividend[WIDTH-1];
    assign sign_b   = op_signed & divisor[WIDTH-1];
    assign mag_a    = sign_a ? -dividend : dividend;
    assign mag_b    = sign_b ? -divisor : divisor;
    assign overflow = op_signed && (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);

    // Quotient sign follows the operand sign mismatch, remainder follows the dividend.
    assign fix_quo  = neg_quo_q ? -quo_step : quo_step;
    assign fix_rem  = neg_rem_q ? -rem_step : rem_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (launch) begin
            neg_quo_q <= sign_a ^ sign_b;
            neg_rem_q <= sign_a;
        end
    end
`else
    logic unused_op_signed;

    assign unused_op_signed = op_signed;
    assign mag_a    = dividend;
    assign mag_b    = divisor;
    assign overflow = 1'b0;
    assign fix_quo  = quo_step;
    assign fix_rem  = rem_step;
`endif

    assign fast_path   = div_zero || overflow;
    assign fast_result = op_rem ? (overflow ? '0 : dividend)
                                : (overflow ? dividend : '1);

    // One restoring step: the trial subtraction is WIDTH+1 bits wide so its MSB is the borrow.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dsr_q};
    assign take     = ~trial[WIDTH];
    assign rem_step = take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_step = {quo_q[WIDTH-2:0], take};

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise latches are inferred.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = fast_path ? FIN : CALC;
                end
            end
            CALC: begin
                busy = 1'b1;
                if (step_q == LAST_STEP) begin
                    state_next = FIN;
                end
            end
            FIN: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // NOTE: datapath registers are reset too, so an aborted operation leaves no stale operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q    <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            rem_sel_q <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        step_q    <= '0;
                        rem_q     <= '0;
                        quo_q     <= mag_a;
                        dsr_q     <= mag_b;
                        rem_sel_q <= op_rem;
                        if (fast_path) begin
                            result <= fast_result;
                        end
                    end
                end
                CALC: begin
                    rem_q  <= rem_step;
                    quo_q  <= quo_step;
                    step_q <= step_q + CW'(1);
                    if (step_q == LAST_STEP) begin
                        result <= rem_sel_q ? fix_rem : fix_quo;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed literal cases plus randomized traffic,
// all compared every cycle against a latency/arithmetic model of the divider.
module tb_iter_divider;

    localparam int WIDTH = 32;
`ifdef DIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b1;
    logic        start     = 1'b0;
    logic        op_signed = 1'b0;
    logic        op_rem    = 1'b0;
    logic [31:0] dividend  = '0;
    logic [31:0] divisor   = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int tests = 0;
    int fails = 0;

    // Model state: busy cycles still to come (done is the last), and the held result.
    int          m_left    = 0;
    logic [31:0] m_result  = '0;
    logic [31:0] m_pending = '0;

    iter_divider #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_signed (op_signed),
        .op_rem    (op_rem),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails <= 30) begin
                $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
            end
        end
    endtask

    function automatic bit is_fast(bit sgn, logic [31:0] a, logic [31:0] b);
        return (b == 0) || (SIGNED_EN && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model_result(bit sgn, bit rem, logic [31:0] a, logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        longint      sa;
        longint      sb;
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (SIGNED_EN && sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (SIGNED_EN && sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = 32'(sa / sb);
            r  = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return rem ? r : q;
    endfunction

    // Reference model: accept start when idle, count down the stated latency.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left   = 0;
            m_result = '0;
        end else begin
            if (m_left == 0) begin
                if (start) begin
                    m_pending = model_result(op_signed, op_rem, dividend, divisor);
                    m_left    = is_fast(op_signed, dividend, divisor) ? 1 : WIDTH + 1;
                end
            end else begin
                m_left--;
            end
            if (m_left == 1) begin
                m_result = m_pending;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", 32'(busy), 32'(m_left != 0));
        check("done", 32'(done), 32'(m_left == 1));
        check("result", result, m_result);
    end

    // Launch one op from idle, wait (bounded) for done, check latency and a literal result.
    task automatic run_op(input string name, input bit sgn, input bit rem,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit disturb);
        int edges;
        op_signed = sgn;
        op_rem    = rem;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        while (!done && edges < 100) begin
            @(negedge clk);
            edges++;
            if (disturb && edges == 5) begin
                start    = 1'b1;
                dividend = 32'hDEAD_BEEF;
                divisor  = 32'h0000_0003;
                op_rem   = ~rem;
            end
            if (disturb && edges == 6) begin
                start    = 1'b0;
                dividend = $urandom;
            end
        end
        check({name, "_latency"}, 32'(edges), is_fast(sgn, a, b) ? 32'd1 : 32'(WIDTH + 1));
        check(name, result, exp);
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_operand(bit is_divisor);
        case ($urandom_range(0, 7))
            0:       return is_divisor ? 32'h0 : 32'h8000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'($urandom_range(1, 15));
            3:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op("div0_quo", 1'b0, 1'b0, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF, 1'b0);
        run_op("div0_rem", 1'b0, 1'b1, 32'h1234_5678, 32'h0, 32'h1234_5678, 1'b0);
`ifdef DIV_SIGNED_EN
        run_op("div_m7_2", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_m7_2", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        run_op("div_7_m2", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_7_m2", 1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op("ovf_quo", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("ovf_rem", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("sdiv0_rem", 1'b1, 1'b1, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 1'b0);
`else
        run_op("unsigned_only_div", 1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
        run_op("unsigned_only_min", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        run_op("unsigned_only_rem", 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
`endif
        run_op("ignore_restart", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 1'b1);

        // Asynchronous abort between clock edges in the middle of CALC.
        op_signed = 1'b0;
        op_rem    = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", result, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("after_reset", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 1'b0);

        // Randomized traffic, including start held high across back-to-back operations.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                op_signed = 1'($urandom_range(0, 1));
                op_rem    = 1'($urandom_range(0, 1));
                dividend  = rand_operand(1'b0);
                divisor   = rand_operand(1'b1);
            end
            start = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("final_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
